// File: rtl/fp_issue_arbiter.sv
// Round-robin issue arbiter for the shared FP pipeline: grants one thread a
// multi-subcycle burst, tracks per-thread bursts in flight, honours rollbacks.
package fp_issue_pkg;
  typedef enum logic [1:0] {
    PIPE_INT = 2'd0,
    PIPE_MEM = 2'd1,
    PIPE_FP  = 2'd2,
    PIPE_BR  = 2'd3
  } pipeline_sel_t;

  typedef logic [3:0] subcycle_t;
endpackage

module fp_issue_arbiter
  import fp_issue_pkg::*;
#(
  parameter int NUM_THREADS  = 4,
  parameter int MAX_INFLIGHT = 2,
  localparam int TW = $clog2(NUM_THREADS),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_THREADS-1:0]            ts_fp_request,
  input  logic [NUM_THREADS-1:0][3:0]       ts_fp_num_subcycles,
  input  logic                              wb_rollback_en,
  input  logic [TW-1:0]                     wb_rollback_thread_idx,
  input  pipeline_sel_t                     wb_rollback_pipeline,
  input  logic                              fx_done_en,
  input  logic [TW-1:0]                     fx_done_thread_idx,
  output logic                              fp_issue_valid,
  output logic [TW-1:0]                     fp_issue_thread_idx,
  output subcycle_t                         fp_issue_subcycle,
  output logic                              fp_issue_last,
  output logic [NUM_THREADS-1:0]            fp_ack
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                          state_q, state_d;
  logic [TW-1:0]                   last_q, last_d;
  logic [TW-1:0]                   thread_q, thread_d;
  subcycle_t                       len_q, len_d;
  subcycle_t                       sub_q, sub_d;
  logic [NUM_THREADS-1:0][CW-1:0]  inflight_q;

  logic                            rb_mem;
  logic                            rb_burst;
  logic [NUM_THREADS-1:0]          eligible;
  logic                            grant_valid;
  logic [TW-1:0]                   grant_idx;
  logic [TW-1:0]                   cand;

  assign rb_mem   = wb_rollback_en && (wb_rollback_pipeline == PIPE_MEM);
  assign rb_burst = (state_q == BURST) && rb_mem && (wb_rollback_thread_idx == thread_q);

  // NOTE: every signal driven from always_comb gets a default before any branch,
  // otherwise a missed path infers a latch.
  always_comb begin : eligibility
    eligible = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = ts_fp_request[i]
                 && (inflight_q[i] < CW'(MAX_INFLIGHT))
                 && !(rb_mem && (wb_rollback_thread_idx == TW'(i)));
    end
  end

  // Search order starts one past the last winner and wraps through it.
  always_comb begin : arbitrate
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand = last_q + TW'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    last_d   = last_q;
    thread_d = thread_q;
    len_d    = len_q;
    sub_d    = sub_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_d   = grant_idx;
          thread_d = grant_idx;
          len_d    = ts_fp_num_subcycles[grant_idx];
          sub_d    = subcycle_t'(1);
          if (ts_fp_num_subcycles[grant_idx] != 4'd0) state_d = BURST;
        end
      end
      BURST: begin
        if (rb_burst || (sub_q == len_q)) state_d = IDLE;
        else                              sub_d   = sub_q + subcycle_t'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    fp_issue_valid      = 1'b0;
    fp_issue_thread_idx = '0;
    fp_issue_subcycle   = '0;
    fp_issue_last       = 1'b0;
    fp_ack              = '0;
    if (!reset) begin
      if (state_q == IDLE && grant_valid) begin
        fp_issue_valid      = 1'b1;
        fp_issue_thread_idx = grant_idx;
        fp_issue_last       = (ts_fp_num_subcycles[grant_idx] == 4'd0);
        fp_ack[grant_idx]   = fp_issue_last;
      end else if (state_q == BURST && !rb_burst) begin
        fp_issue_valid      = 1'b1;
        fp_issue_thread_idx = thread_q;
        fp_issue_subcycle   = sub_q;
        fp_issue_last       = (sub_q == len_q);
        fp_ack[thread_q]    = fp_issue_last;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= TW'(NUM_THREADS - 1);
      thread_q   <= '0;
      len_q      <= '0;
      sub_q      <= '0;
      // NOTE: the counter array is tiny flop storage whose value gates
      // eligibility, so it is reset like any other state.
      inflight_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      thread_q <= thread_d;
      len_q    <= len_d;
      sub_q    <= sub_d;
      for (int i = 0; i < NUM_THREADS; i++) begin
        if ((state_q == IDLE) && grant_valid && (grant_idx == TW'(i))
            && !(fx_done_en && fx_done_thread_idx == TW'(i))) begin
          if (inflight_q[i] != CW'(MAX_INFLIGHT)) inflight_q[i] <= inflight_q[i] + CW'(1);
        end else if (fx_done_en && (fx_done_thread_idx == TW'(i))
                     && !((state_q == IDLE) && grant_valid && (grant_idx == TW'(i)))) begin
          if (inflight_q[i] != '0) inflight_q[i] <= inflight_q[i] - CW'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_done_underflow: assert property (@(posedge clk) disable iff (reset)
    !(fx_done_en && inflight_q[fx_done_thread_idx] == '0));
  a_request_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == BURST) |-> ts_fp_request[thread_q]);
`endif

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Self-checking bench for fp_issue_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_fp_issue_arbiter;
  import fp_issue_pkg::*;

  localparam int NT   = 4;
  localparam int MAXI = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NT-1:0]      ts_fp_request;
  logic [NT-1:0][3:0] ts_fp_num_subcycles;
  logic               wb_rollback_en;
  logic [1:0]         wb_rollback_thread_idx;
  pipeline_sel_t      wb_rollback_pipeline;
  logic               fx_done_en;
  logic [1:0]         fx_done_thread_idx;
  logic               fp_issue_valid;
  logic [1:0]         fp_issue_thread_idx;
  subcycle_t          fp_issue_subcycle;
  logic               fp_issue_last;
  logic [NT-1:0]      fp_ack;

  fp_issue_arbiter #(.NUM_THREADS(NT), .MAX_INFLIGHT(MAXI)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ts_fp_request          (ts_fp_request),
    .ts_fp_num_subcycles    (ts_fp_num_subcycles),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .wb_rollback_pipeline   (wb_rollback_pipeline),
    .fx_done_en             (fx_done_en),
    .fx_done_thread_idx     (fx_done_thread_idx),
    .fp_issue_valid         (fp_issue_valid),
    .fp_issue_thread_idx    (fp_issue_thread_idx),
    .fp_issue_subcycle      (fp_issue_subcycle),
    .fp_issue_last          (fp_issue_last),
    .fp_ack                 (fp_ack)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an outstanding burst (if any) plus per-thread burst counts.
  bit        m_busy    = 1'b0;
  int        m_thr     = 0;
  int        m_len     = 0;
  int        m_sub     = 0;
  int        m_last_gr = NT - 1;
  int        m_infl[NT] = '{default: 0};
  logic [NT-1:0] m_ack = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] pack_slot(input logic v, input int idx, input int sub,
                                            input logic last, input logic [3:0] ack);
    return {v, 2'(idx), 4'(sub), last, ack};
  endfunction

  function automatic logic [11:0] dut_slot();
    return {fp_issue_valid, fp_issue_thread_idx, fp_issue_subcycle, fp_issue_last, fp_ack};
  endfunction

  always @(negedge clk) begin : scoreboard
    int   grant, t, cnt;
    logic ev, el, rb;
    int   ei, es;
    logic [3:0] ea;
    grant = -1; ev = 1'b0; ei = 0; es = 0; el = 1'b0; ea = '0;
    rb = wb_rollback_en && (wb_rollback_pipeline == PIPE_MEM);
    if (!reset) begin
      if (!m_busy) begin
        for (int k = 1; k <= NT; k++) begin
          t = (m_last_gr + k) % NT;
          if (grant < 0 && ts_fp_request[t] && m_infl[t] < MAXI
              && !(rb && int'(wb_rollback_thread_idx) == t)) grant = t;
        end
        if (grant >= 0) begin
          ev = 1'b1; ei = grant;
          el = (ts_fp_num_subcycles[grant] == 4'd0);
          ea = el ? 4'(1 << grant) : 4'd0;
        end
      end else if (!(rb && int'(wb_rollback_thread_idx) == m_thr)) begin
        ev = 1'b1; ei = m_thr; es = m_sub;
        el = (m_sub == m_len);
        ea = el ? 4'(1 << m_thr) : 4'd0;
      end
    end
    check("cycle_slot", 32'(dut_slot()), 32'(pack_slot(ev, ei, es, el, ea)));
    m_ack = ea;
    if (reset) begin
      m_busy = 1'b0; m_last_gr = NT - 1;
      for (int i = 0; i < NT; i++) m_infl[i] = 0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        cnt = m_infl[i] + ((grant == i) ? 1 : 0)
              - ((fx_done_en && int'(fx_done_thread_idx) == i) ? 1 : 0);
        m_infl[i] = (cnt < 0) ? 0 : ((cnt > MAXI) ? MAXI : cnt);
      end
      if (grant >= 0) begin
        m_last_gr = grant;
        if (ts_fp_num_subcycles[grant] != 4'd0) begin
          m_busy = 1'b1; m_thr = grant; m_sub = 1;
          m_len = int'(ts_fp_num_subcycles[grant]);
        end
      end else if (m_busy) begin
        if (rb && int'(wb_rollback_thread_idx) == m_thr) m_busy = 1'b0;
        else if (m_sub == m_len)                         m_busy = 1'b0;
        else                                             m_sub++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation for the current cycle, then advance one cycle.
  task automatic cyc(input string name, input logic v, input int idx, input int sub,
                     input logic last, input logic [3:0] ack);
    @(negedge clk);
    check(name, 32'(dut_slot()), 32'(pack_slot(v, idx, sub, last, ack)));
    tick();
  endtask

  task automatic drain();
    int n;
    ts_fp_request = '0;
    for (int t = 0; t < NT; t++) begin
      n = m_infl[t];
      repeat (n) begin
        fx_done_en = 1'b1; fx_done_thread_idx = 2'(t);
        tick();
      end
    end
    fx_done_en = 1'b0;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    ts_fp_request = 4'hF;
    ts_fp_num_subcycles = '0;
    wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0; wb_rollback_pipeline = PIPE_MEM;
    fx_done_en = 1'b0; fx_done_thread_idx = '0;
    cyc("reset_outputs_zero", 0, 0, 0, 0, 4'b0000);
    reset = 1'b0;

    // Four single-subcycle requests: one grant per cycle in thread order.
    for (int i = 0; i < NT; i++) begin
      ts_fp_request = 4'(4'hF << i);
      cyc($sformatf("rr_len0_t%0d", i), 1, i, 0, 1, 4'(1 << i));
    end
    drain();

    // Four-subcycle burst on T2; T0 arrives mid-burst and waits for the end.
    ts_fp_request = 4'b0100; ts_fp_num_subcycles[2] = 4'd3;
    cyc("burst_t2_s0", 1, 2, 0, 0, 4'b0000);
    ts_fp_request = 4'b0101; ts_fp_num_subcycles[0] = 4'd0;
    cyc("burst_t2_s1", 1, 2, 1, 0, 4'b0000);
    cyc("burst_t2_s2", 1, 2, 2, 0, 4'b0000);
    cyc("burst_t2_s3", 1, 2, 3, 1, 4'b0100);
    ts_fp_request = 4'b0001;
    cyc("t0_after_burst", 1, 0, 0, 1, 4'b0001);
    drain();

    // In-flight limit: third T1 burst blocked until a done pulse arrives.
    ts_fp_request = 4'b0010; ts_fp_num_subcycles[1] = 4'd0;
    cyc("infl_t1_first", 1, 1, 0, 1, 4'b0010);
    cyc("infl_t1_second", 1, 1, 0, 1, 4'b0010);
    cyc("infl_t1_blocked_a", 0, 0, 0, 0, 4'b0000);
    cyc("infl_t1_blocked_b", 0, 0, 0, 0, 4'b0000);
    fx_done_en = 1'b1; fx_done_thread_idx = 2'd1;
    cyc("infl_t1_done_cycle", 0, 0, 0, 0, 4'b0000);
    fx_done_en = 1'b0;
    cyc("infl_t1_regrant", 1, 1, 0, 1, 4'b0010);
    drain();

    // Rollback of an idle requester only masks it for that cycle.
    ts_fp_request = 4'b0001; ts_fp_num_subcycles[0] = 4'd0;
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd0; wb_rollback_pipeline = PIPE_MEM;
    cyc("idle_rollback_masks", 0, 0, 0, 0, 4'b0000);
    wb_rollback_en = 1'b0;
    cyc("idle_rollback_next", 1, 0, 0, 1, 4'b0001);
    drain();

    // Rollback of an 8-subcycle T1 burst at subcycle 2; non-MEM rollback ignored.
    ts_fp_request = 4'b0010; ts_fp_num_subcycles[1] = 4'd7;
    cyc("rb_t1_s0", 1, 1, 0, 0, 4'b0000);
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1; wb_rollback_pipeline = PIPE_FP;
    cyc("rb_nonmem_s1", 1, 1, 1, 0, 4'b0000);
    wb_rollback_pipeline = PIPE_MEM;
    cyc("rb_mem_s2_dropped", 0, 0, 0, 0, 4'b0000);
    wb_rollback_en = 1'b0;
    check("rb_model_inflight_t1", 32'(m_infl[1]), 32'd1);
    ts_fp_num_subcycles[1] = 4'd0;
    cyc("rb_back_to_idle", 1, 1, 0, 1, 4'b0010);
    drain();

    // Simultaneous issue and done on T3 leaves its count unchanged.
    ts_fp_request = 4'b1000; ts_fp_num_subcycles[3] = 4'd0;
    cyc("sim_t3_first", 1, 3, 0, 1, 4'b1000);
    fx_done_en = 1'b1; fx_done_thread_idx = 2'd3;
    cyc("sim_t3_issue_and_done", 1, 3, 0, 1, 4'b1000);
    fx_done_en = 1'b0;
    check("sim_model_inflight_t3", 32'(m_infl[3]), 32'd1);
    cyc("sim_t3_second_slot", 1, 3, 0, 1, 4'b1000);
    cyc("sim_t3_now_full", 0, 0, 0, 0, 4'b0000);
    drain();

    // Reset mid-burst abandons it; T0 wins the first arbitration afterwards.
    ts_fp_request = 4'b0100; ts_fp_num_subcycles[2] = 4'd5;
    cyc("rst_t2_s0", 1, 2, 0, 0, 4'b0000);
    cyc("rst_t2_s1", 1, 2, 1, 0, 4'b0000);
    reset = 1'b1;
    cyc("rst_mid_burst_zero", 0, 0, 0, 0, 4'b0000);
    reset = 1'b0;
    check("rst_model_counters", 32'(m_infl[0] + m_infl[1] + m_infl[2] + m_infl[3]), 32'd0);
    ts_fp_request = 4'b0101; ts_fp_num_subcycles[0] = 4'd0;
    cyc("rst_t0_first", 1, 0, 0, 1, 4'b0001);
    ts_fp_request = 4'b0100;
    for (int s = 0; s <= 5; s++)
      cyc($sformatf("rst_t2_full_s%0d", s), 1, 2, s, s == 5, (s == 5) ? 4'b0100 : 4'b0000);
    drain();

    // Randomized traffic; the scoreboard checks every cycle.
    repeat (3000) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NT; i++) begin
        if (m_ack[i]) ts_fp_request[i] = 1'b0;
        else if (!ts_fp_request[i] && $urandom_range(0, 3) == 0) begin
          ts_fp_request[i] = 1'b1;
          ts_fp_num_subcycles[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
      end
      wb_rollback_en = ($urandom_range(0, 7) == 0);
      wb_rollback_thread_idx = 2'($urandom_range(0, 3));
      wb_rollback_pipeline = pipeline_sel_t'(2'($urandom_range(0, 3)));
      t = $urandom_range(0, NT - 1);
      fx_done_en = (m_infl[t] > 0) && ($urandom_range(0, 2) == 0);
      fx_done_thread_idx = 2'(t);
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_issue_arbiter.md
FP_ISSUE_ARBITER -- requirements
Module: fp_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, number of requesting hardware threads (power of 2, >=2).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, maximum FP bursts in flight per thread.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ts_fp_request  input  NUM_THREADS  per-thread request, held until acked.
REQ-006 SHALL have port ts_fp_num_subcycles  input  NUM_THREADS x 4  per-thread burst length minus 1 (0 = 1 subcycle, 15 = 16).
REQ-007 SHALL have port wb_rollback_en / wb_rollback_thread_idx / wb_rollback_pipeline  input  1 / clog2(NUM_THREADS) / pipeline_sel_t  writeback rollback.
REQ-008 SHALL have port fx_done_en / fx_done_thread_idx  input  1 / clog2(NUM_THREADS)  one pulse per burst leaving the FP pipeline, squashed or not.
REQ-009 SHALL have port fp_issue_valid / fp_issue_thread_idx / fp_issue_subcycle  output  1 / clog2(NUM_THREADS) / subcycle_t  issue slot to FP stage 1.
REQ-010 SHALL have port fp_issue_last  output  1  current slot is the final subcycle of the burst.
REQ-011 SHALL have port fp_ack  output  NUM_THREADS  one-hot, pulses in cycle of final subcycle of a completed burst.

Function
REQ-012 SHALL implement states IDLE and BURST.
REQ-013 In IDLE, eligible thread = request asserted, inflight count < MAX_INFLIGHT, and not rolled back this cycle.
REQ-014 In IDLE with >=1 eligible thread, SHALL select by round-robin starting at (last_granted+1) mod NUM_THREADS, issue subcycle 0 in the same cycle (combinational fp_issue_valid), latch thread and length.
REQ-015 If selected length is 0, SHALL assert fp_issue_last and fp_ack same cycle and remain IDLE; else go to BURST.
REQ-016 In BURST, SHALL issue one subcycle per cycle, incrementing fp_issue_subcycle by 1, no gaps.
REQ-017 SHALL leave BURST to IDLE after issuing subcycle == latched length, asserting fp_issue_last and fp_ack that cycle.
REQ-018 SHALL update last_granted only when a burst is granted; no grant while in BURST.
REQ-019 Rollback match = wb_rollback_en && thread_idx equals burst thread && wb_rollback_pipeline == PIPE_MEM.
REQ-020 On rollback match in BURST, SHALL deassert fp_issue_valid that cycle, not assert fp_ack, return to IDLE; issued subcycles remain counted as one inflight burst.
REQ-021 Rollback for a thread in IDLE SHALL only make that thread ineligible that cycle.
REQ-022 Inflight counter per thread SHALL increment on subcycle-0 issue, decrement on fx_done_en for that thread; simultaneous increment and decrement SHALL leave it unchanged.
REQ-023 Counter SHALL saturate at 0 and MAX_INFLIGHT; decrement at 0 is a protocol error flagged by a simulation assertion.
REQ-024 With no eligible thread in IDLE, SHALL hold fp_issue_valid = 0 and fp_issue_subcycle = 0.
REQ-025 fp_ack SHALL never assert for a thread without request; dropping a request mid-burst is illegal (assertion).
REQ-026 fp_issue_thread_idx and fp_issue_subcycle SHALL be 0 whenever fp_issue_valid = 0.

Reset
REQ-027 On reset SHALL enter IDLE, last_granted = NUM_THREADS-1 (thread 0 first), all inflight counters 0.
REQ-028 During reset cycle all outputs SHALL be 0 regardless of inputs; reset mid-burst abandons the burst with no fp_ack.

Verification
REQ-029 Requests {0,1,2,3}, all length 0 -> grants T0,T1,T2,T3 on four consecutive cycles, each with fp_issue_last and fp_ack.
REQ-030 T2 length 3 alone -> subcycles 0,1,2,3 on four cycles, fp_ack[2] only on 4th; T0 request arriving at cycle 2 issues on cycle 5.
REQ-031 T1 bursts with MAX_INFLIGHT=2 and no fx_done -> third T1 burst blocked; fx_done_en for T1 -> next cycle eligible.
REQ-032 Rollback (PIPE_MEM, T1) during T1 subcycle 2 of 8 -> valid drops that cycle, no fp_ack, IDLE, inflight[1] = 1.
REQ-033 Issue and fx_done_en for T3 same cycle at count 1 -> count stays 1.
REQ-034 Reset asserted mid-burst -> next cycle IDLE, counters 0, T0 wins first arbitration.
